// File: rtl/pipe_pkg.sv
// Shared constants and types for the 5-stage RV32I pipeline: widths, ALU opcodes
// and the ID/EX register image with its all-zero bubble value.
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        id_ex_ctrl_t           ctrl;
    } id_ex_regs_t;

    localparam id_ex_regs_t BUBBLE_REGS = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the ID instruction.
// Purely combinational; kept separate so a future hazard unit can reuse it.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  load_use
);

    // Conservative match: source usage by the ID instruction is not decoded
    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall/bubble insertion.
// Optional macro ID_EX_PERF_CNT_EN adds a saturating load-use bubble counter.
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold_ex,
    input  logic                  flush_ex,
    input  logic                  valid_id,
    input  logic [XLEN-1:0]       pc_id,
    input  logic [XLEN-1:0]       rs1_data_id,
    input  logic [XLEN-1:0]       rs2_data_id,
    input  logic [XLEN-1:0]       imm_id,
    input  logic [REG_ADDR_W-1:0] Rs1_id,
    input  logic [REG_ADDR_W-1:0] Rs2_id,
    input  logic [REG_ADDR_W-1:0] Rd_id,
    input  logic                  reg_write_id,
    input  logic                  mem_read_id,
    input  logic                  mem_write_id,
    input  logic                  mem_to_reg_id,
    input  logic                  alu_src_id,
    input  logic                  branch_id,
    input  logic [ALU_OP_W-1:0]   alu_op_id,
    output logic                  valid_id_ex,
    output logic [XLEN-1:0]       pc_id_ex,
    output logic [XLEN-1:0]       rs1_data_id_ex,
    output logic [XLEN-1:0]       rs2_data_id_ex,
    output logic [XLEN-1:0]       imm_id_ex,
    output logic [REG_ADDR_W-1:0] Rs1_id_ex,
    output logic [REG_ADDR_W-1:0] Rs2_id_ex,
    output logic [REG_ADDR_W-1:0] Rd_id_ex,
    output logic                  reg_write_id_ex,
    output logic                  mem_read_id_ex,
    output logic                  mem_write_id_ex,
    output logic                  mem_to_reg_id_ex,
    output logic                  alu_src_id_ex,
    output logic                  branch_id_ex,
    output logic [ALU_OP_W-1:0]   alu_op_id_ex,
    output logic                  stall_if_id
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           load_use_bubbles
`endif
);

    id_ex_regs_t stage_r;
    id_ex_regs_t stage_nxt_s;
    id_ex_regs_t id_in_s;
    logic        load_use_s;

    load_use_detect u_load_use_detect (
        .ex_valid    (stage_r.valid),
        .ex_mem_read (stage_r.ctrl.mem_read),
        .ex_rd       (stage_r.rd),
        .id_valid    (valid_id),
        .id_rs1      (Rs1_id),
        .id_rs2      (Rs2_id),
        .load_use    (load_use_s)
    );

    // A squashed instruction upstream must not freeze fetch
    assign stall_if_id = load_use_s && !flush_ex && !reset;

    // Pack the ID-side inputs into the register image
    always_comb begin
        id_in_s                 = BUBBLE_REGS;
        id_in_s.valid           = valid_id;
        id_in_s.pc              = pc_id;
        id_in_s.rs1_data        = rs1_data_id;
        id_in_s.rs2_data        = rs2_data_id;
        id_in_s.imm             = imm_id;
        id_in_s.rs1             = Rs1_id;
        id_in_s.rs2             = Rs2_id;
        id_in_s.rd              = Rd_id;
        id_in_s.ctrl.reg_write  = reg_write_id;
        id_in_s.ctrl.mem_read   = mem_read_id;
        id_in_s.ctrl.mem_write  = mem_write_id;
        id_in_s.ctrl.mem_to_reg = mem_to_reg_id;
        id_in_s.ctrl.alu_src    = alu_src_id;
        id_in_s.ctrl.branch     = branch_id;
        id_in_s.ctrl.alu_op     = alu_op_id;
    end

    // Next-state selection: flush > hold > load-use bubble > capture
    always_comb begin
        stage_nxt_s = BUBBLE_REGS;
        if (flush_ex) begin
            stage_nxt_s = BUBBLE_REGS;
        end else if (hold_ex) begin
            stage_nxt_s = stage_r;
        end else if (load_use_s || !valid_id) begin
            // Invalid slots are zeroed completely so forwarding can never match them
            stage_nxt_s = BUBBLE_REGS;
        end else begin
            stage_nxt_s = id_in_s;
        end
    end

    // Pipeline register with synchronous reset to a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_r <= BUBBLE_REGS;
        end else begin
            stage_r <= stage_nxt_s;
        end
    end

    assign valid_id_ex      = stage_r.valid;
    assign pc_id_ex         = stage_r.pc;
    assign rs1_data_id_ex   = stage_r.rs1_data;
    assign rs2_data_id_ex   = stage_r.rs2_data;
    assign imm_id_ex        = stage_r.imm;
    assign Rs1_id_ex        = stage_r.rs1;
    assign Rs2_id_ex        = stage_r.rs2;
    assign Rd_id_ex         = stage_r.rd;
    assign reg_write_id_ex  = stage_r.ctrl.reg_write;
    assign mem_read_id_ex   = stage_r.ctrl.mem_read;
    assign mem_write_id_ex  = stage_r.ctrl.mem_write;
    assign mem_to_reg_id_ex = stage_r.ctrl.mem_to_reg;
    assign alu_src_id_ex    = stage_r.ctrl.alu_src;
    assign branch_id_ex     = stage_r.ctrl.branch;
    assign alu_op_id_ex     = stage_r.ctrl.alu_op;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;
    logic        bubble_ins_s;

    assign bubble_ins_s = load_use_s && !flush_ex && !hold_ex;

    // Saturating count of bubbles actually inserted for load-use hazards
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_r <= 32'd0;
        end else if (bubble_ins_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 32'd1;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign load_use_bubbles = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes hand-computed expectations,
// a monitor pops and compares after each clock edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        asrc;
        logic        br;
        logic [3:0]  op;
    } id_t;

    typedef struct packed {
        id_t         regs;
        logic        stall;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, hold_ex, flush_ex, valid_id;
    logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
    logic [4:0]  Rs1_id, Rs2_id, Rd_id;
    logic        reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id, alu_src_id, branch_id;
    logic [3:0]  alu_op_id;
    logic        valid_id_ex;
    logic [31:0] pc_id_ex, rs1_data_id_ex, rs2_data_id_ex, imm_id_ex;
    logic [4:0]  Rs1_id_ex, Rs2_id_ex, Rd_id_ex;
    logic        reg_write_id_ex, mem_read_id_ex, mem_write_id_ex, mem_to_reg_id_ex;
    logic        alu_src_id_ex, branch_id_ex;
    logic [3:0]  alu_op_id_ex;
    logic        stall_if_id;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] load_use_bubbles;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .hold_ex(hold_ex), .flush_ex(flush_ex),
        .valid_id(valid_id), .pc_id(pc_id), .rs1_data_id(rs1_data_id),
        .rs2_data_id(rs2_data_id), .imm_id(imm_id), .Rs1_id(Rs1_id), .Rs2_id(Rs2_id),
        .Rd_id(Rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
        .mem_write_id(mem_write_id), .mem_to_reg_id(mem_to_reg_id),
        .alu_src_id(alu_src_id), .branch_id(branch_id), .alu_op_id(alu_op_id),
        .valid_id_ex(valid_id_ex), .pc_id_ex(pc_id_ex), .rs1_data_id_ex(rs1_data_id_ex),
        .rs2_data_id_ex(rs2_data_id_ex), .imm_id_ex(imm_id_ex), .Rs1_id_ex(Rs1_id_ex),
        .Rs2_id_ex(Rs2_id_ex), .Rd_id_ex(Rd_id_ex), .reg_write_id_ex(reg_write_id_ex),
        .mem_read_id_ex(mem_read_id_ex), .mem_write_id_ex(mem_write_id_ex),
        .mem_to_reg_id_ex(mem_to_reg_id_ex), .alu_src_id_ex(alu_src_id_ex),
        .branch_id_ex(branch_id_ex), .alu_op_id_ex(alu_op_id_ex),
        .stall_if_id(stall_if_id)
`ifdef ID_EX_PERF_CNT_EN
        , .load_use_bubbles(load_use_bubbles)
`endif
    );

    function automatic id_t mk(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] rd, input logic rw,
                               input logic mr, input logic [3:0] op);
        id_t t;
        t.valid = v;      t.pc = pc;
        t.d1 = pc ^ 32'hA5A5_0000;  t.d2 = pc ^ 32'h5A5A_0000;  t.imm = pc + 32'd4;
        t.rs1 = r1;  t.rs2 = r2;  t.rd = rd;
        t.rw = rw;   t.mr = mr;   t.mw = 1'b0;  t.m2r = mr;  t.asrc = mr;  t.br = 1'b0;
        t.op = op;
        return t;
    endfunction

    localparam id_t BUB = '0;

    task automatic step(input id_t in, input logic rst, input logic hld, input logic fl,
                        input id_t exp_regs, input logic exp_stall, input logic [31:0] exp_cnt);
        exp_t e;
        @(negedge clk);
        reset = rst;  hold_ex = hld;  flush_ex = fl;
        valid_id = in.valid;  pc_id = in.pc;  rs1_data_id = in.d1;  rs2_data_id = in.d2;
        imm_id = in.imm;  Rs1_id = in.rs1;  Rs2_id = in.rs2;  Rd_id = in.rd;
        reg_write_id = in.rw;  mem_read_id = in.mr;  mem_write_id = in.mw;
        mem_to_reg_id = in.m2r;  alu_src_id = in.asrc;  branch_id = in.br;  alu_op_id = in.op;
        e.regs = exp_regs;  e.stall = exp_stall;  e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: stall sampled just before the edge, registers just after it
    initial begin
        logic stall_seen;
        id_t  got;
        exp_t e;
        forever begin
            @(negedge clk);
            #4 stall_seen = stall_if_id;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {valid_id_ex, pc_id_ex, rs1_data_id_ex, rs2_data_id_ex, imm_id_ex,
                       Rs1_id_ex, Rs2_id_ex, Rd_id_ex, reg_write_id_ex, mem_read_id_ex,
                       mem_write_id_ex, mem_to_reg_id_ex, alu_src_id_ex, branch_id_ex,
                       alu_op_id_ex};
                total++;
                if (got !== e.regs) begin
                    bad++;
                    $display("FAIL regs: got=%h exp=%h", got, e.regs);
                end
                total++;
                if (stall_seen !== e.stall) begin
                    bad++;
                    $display("FAIL stall: got=%b exp=%b", stall_seen, e.stall);
                end
`ifdef ID_EX_PERF_CNT_EN
                total++;
                if (load_use_bubbles !== e.cnt) begin
                    bad++;
                    $display("FAIL bubble_cnt: got=%0d exp=%0d", load_use_bubbles, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        id_t a, l5, d1, l5b, d2, l0, x, a5, y, l5c, z, l6, l7, w, l5d, v1, v2, v3, l5e, inv;
        int  budget;
        a   = mk(1'b1, 32'h100, 5'd1, 5'd2, 5'd3,  1'b1, 1'b0, 4'd0);
        l5  = mk(1'b1, 32'h104, 5'd1, 5'd0, 5'd5,  1'b1, 1'b1, 4'd0);
        d1  = mk(1'b1, 32'h108, 5'd5, 5'd2, 5'd6,  1'b1, 1'b0, 4'd0);
        l5b = mk(1'b1, 32'h10c, 5'd2, 5'd0, 5'd5,  1'b1, 1'b1, 4'd0);
        d2  = mk(1'b1, 32'h110, 5'd2, 5'd5, 5'd7,  1'b1, 1'b0, 4'd1);
        l0  = mk(1'b1, 32'h114, 5'd1, 5'd0, 5'd0,  1'b1, 1'b1, 4'd0);
        x   = mk(1'b1, 32'h118, 5'd0, 5'd3, 5'd8,  1'b1, 1'b0, 4'd0);
        a5  = mk(1'b1, 32'h11c, 5'd1, 5'd2, 5'd5,  1'b1, 1'b0, 4'd0);
        y   = mk(1'b1, 32'h120, 5'd5, 5'd1, 5'd9,  1'b1, 1'b0, 4'd2);
        l5c = mk(1'b1, 32'h124, 5'd1, 5'd0, 5'd5,  1'b1, 1'b1, 4'd0);
        z   = mk(1'b1, 32'h128, 5'd5, 5'd0, 5'd10, 1'b1, 1'b0, 4'd3);
        l6  = mk(1'b1, 32'h12c, 5'd1, 5'd0, 5'd6,  1'b1, 1'b1, 4'd0);
        l7  = mk(1'b1, 32'h130, 5'd6, 5'd0, 5'd7,  1'b1, 1'b1, 4'd0);
        w   = mk(1'b1, 32'h134, 5'd7, 5'd0, 5'd8,  1'b1, 1'b0, 4'd4);
        l5d = mk(1'b1, 32'h138, 5'd1, 5'd0, 5'd5,  1'b1, 1'b1, 4'd0);
        v1  = mk(1'b1, 32'h13c, 5'd5, 5'd1, 5'd11, 1'b1, 1'b0, 4'd0);
        v2  = mk(1'b1, 32'h140, 5'd1, 5'd5, 5'd12, 1'b1, 1'b0, 4'd5);
        v3  = mk(1'b1, 32'h144, 5'd5, 5'd2, 5'd13, 1'b1, 1'b0, 4'd6);
        l5e = mk(1'b1, 32'h148, 5'd1, 5'd0, 5'd5,  1'b1, 1'b1, 4'd0);
        inv = mk(1'b0, 32'h14c, 5'd5, 5'd5, 5'd14, 1'b1, 1'b0, 4'd7);

        reset = 1'b1;  hold_ex = 1'b0;  flush_ex = 1'b0;
        // reset with live ID inputs
        step(a,   1'b1, 1'b0, 1'b0, BUB, 1'b0, 32'd0);
        step(a,   1'b1, 1'b0, 1'b0, BUB, 1'b0, 32'd0);
        // normal capture, then load-use on rs1
        step(a,   1'b0, 1'b0, 1'b0, a,   1'b0, 32'd0);
        step(l5,  1'b0, 1'b0, 1'b0, l5,  1'b0, 32'd0);
        step(d1,  1'b0, 1'b0, 1'b0, BUB, 1'b1, 32'd1);
        step(d1,  1'b0, 1'b0, 1'b0, d1,  1'b0, 32'd1);
        // load-use on rs2
        step(l5b, 1'b0, 1'b0, 1'b0, l5b, 1'b0, 32'd1);
        step(d2,  1'b0, 1'b0, 1'b0, BUB, 1'b1, 32'd2);
        step(d2,  1'b0, 1'b0, 1'b0, d2,  1'b0, 32'd2);
        // lw x0 and non-load producers never stall
        step(l0,  1'b0, 1'b0, 1'b0, l0,  1'b0, 32'd2);
        step(x,   1'b0, 1'b0, 1'b0, x,   1'b0, 32'd2);
        step(a5,  1'b0, 1'b0, 1'b0, a5,  1'b0, 32'd2);
        step(y,   1'b0, 1'b0, 1'b0, y,   1'b0, 32'd2);
        // flush beats load-use
        step(l5c, 1'b0, 1'b0, 1'b0, l5c, 1'b0, 32'd2);
        step(z,   1'b0, 1'b0, 1'b1, BUB, 1'b0, 32'd2);
        step(z,   1'b0, 1'b0, 1'b0, z,   1'b0, 32'd2);
        // back-to-back dependent loads
        step(l6,  1'b0, 1'b0, 1'b0, l6,  1'b0, 32'd2);
        step(l7,  1'b0, 1'b0, 1'b0, BUB, 1'b1, 32'd3);
        step(l7,  1'b0, 1'b0, 1'b0, l7,  1'b0, 32'd3);
        step(w,   1'b0, 1'b0, 1'b0, BUB, 1'b1, 32'd4);
        step(w,   1'b0, 1'b0, 1'b0, w,   1'b0, 32'd4);
        // hold across a load-use, then one bubble
        step(l5d, 1'b0, 1'b0, 1'b0, l5d, 1'b0, 32'd4);
        step(v1,  1'b0, 1'b1, 1'b0, l5d, 1'b1, 32'd4);
        step(v2,  1'b0, 1'b1, 1'b0, l5d, 1'b1, 32'd4);
        step(v3,  1'b0, 1'b1, 1'b0, l5d, 1'b1, 32'd4);
        step(v3,  1'b0, 1'b0, 1'b0, BUB, 1'b1, 32'd5);
        step(v3,  1'b0, 1'b0, 1'b0, v3,  1'b0, 32'd5);
        // plain hold with no hazard
        step(a,   1'b0, 1'b1, 1'b0, v3,  1'b0, 32'd5);
        // invalid ID slot behind a load: no stall, captured as bubble
        step(l5e, 1'b0, 1'b0, 1'b0, l5e, 1'b0, 32'd5);
        step(inv, 1'b0, 1'b0, 1'b0, BUB, 1'b0, 32'd5);
        step(a,   1'b0, 1'b0, 1'b0, a,   1'b0, 32'd5);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
